// File: rtl/uart_tx_ascii.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ascii
// Description : 8-bit characters arrive over valid/ready into a small FIFO and
//               leave as UART 8N1 frames on a single idle-high serial pin.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ascii #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e              state_q;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BAUD_W-1:0]   baud_q;
  logic [2:0]          bit_q;
  logic [7:0]          shift_q;
  logic                tx_q;

  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                baud_last;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  assign baud_last  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  // A pop happens from IDLE, or on the last STOP cycle so frames run gap-free.
  assign pop        = !fifo_empty &&
                      ((state_q == S_IDLE) || (state_q == S_STOP && baud_last));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ascii.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ascii
// Description : Directed bench for uart_tx_ascii; tx is logged every cycle and
//               whole frames are compared against hand-built 8N1 bit patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ascii;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic tx_hist [0:4095];

  uart_tx_ascii #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // tx_hist[k] holds the tx level that follows clock edge k.
  always @(negedge clk) if (cyc < 4096) tx_hist[cyc] <= tx;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input int s, input logic [7:0] d);
    logic [39:0] e;
    logic [39:0] o;
    for (int k = 0; k < FRAME; k++) begin
      int b;
      b = k / CPB;
      e[k] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
      o[k] = (s + k < 4096) ? tx_hist[s+k] : 1'bx;
    end
    chk(tag, {24'b0, o}, {24'b0, e});
  endtask

  task automatic push(input logic [7:0] d, output int acc, output int stalls);
    in_data  = d;
    in_valid = 1'b1;
    stalls   = 0;
    while (!in_ready && stalls < 2000) begin
      step();
      stalls++;
    end
    if (stalls >= 2000) chk("push_timeout", in_ready, 1);
    step();
    acc = cyc;
  endtask

  task automatic wait_idle(output int c);
    int g;
    g = 0;
    while (busy && g < 2000) begin
      step();
      g++;
    end
    if (g >= 2000) chk("idle_timeout", busy, 0);
    c = cyc;
  endtask

  initial begin
    int    a, b, c, q, m, z, st, nstall;
    int    acc [9];
    string msg;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) step();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", fifo_count, 0);
    reset = 1'b0;
    step();

    // Single 'G'
    push(8'h47, a, st);
    in_valid = 1'b0;
    chk("g_count", fifo_count, 1);
    chk("g_tx_idle", tx, 1);
    step();
    chk("g_start", tx, 0);
    chk("g_count_popped", fifo_count, 0);
    wait_idle(c);
    chk("g_len", c - a, FRAME + 1);
    chk_frame("g_frame", a + 1, 8'h47);

    // Burst "Guatemala" with in_valid held throughout
    msg    = "Guatemala";
    nstall = 0;
    for (int i = 0; i < 9; i++) begin
      if (!in_ready) begin
        chk($sformatf("burst_full_cnt%0d", i), fifo_count, DEPTH);
        nstall++;
      end
      push(msg[i], acc[i], st);
    end
    in_valid = 1'b0;
    chk("burst_nstall", nstall, 4);
    wait_idle(c);
    chk("burst_len", c - (acc[0] + 1), 9 * FRAME);
    for (int i = 0; i < 9; i++)
      chk_frame($sformatf("burst_f%0d", i), acc[0] + 1 + FRAME * i, msg[i]);

    // Push landing on the same edge as the end-of-STOP pop
    push(8'h61, a, st);
    push(8'h62, b, st);
    in_valid = 1'b0;
    while (cyc < a + FRAME) step();
    push(8'h63, b, st);
    in_valid = 1'b0;
    chk("pp_acc", b, a + FRAME + 1);
    chk("pp_count", fifo_count, 1);
    chk("pp_tx", tx, 0);
    wait_idle(c);
    chk("pp_len", c - a, 3 * FRAME + 1);
    chk_frame("pp_f0", a + 1, 8'h61);
    chk_frame("pp_f1", a + 1 + FRAME, 8'h62);
    chk_frame("pp_f2", a + 1 + 2 * FRAME, 8'h63);

    // Reset during DATA bit 3 of 0x41 with two bytes queued
    push(8'h41, m, st);
    push(8'h42, b, st);
    push(8'h43, b, st);
    in_valid = 1'b0;
    while (cyc < m + 18) step();
    chk("mid_tx_pre", tx, 0);
    chk("mid_count_pre", fifo_count, 2);
    #2 reset = 1'b1;
    #1;
    chk("mid_tx", tx, 1);
    chk("mid_count", fifo_count, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", in_ready, 1);
    step();
    step();
    reset = 1'b0;
    step();
    push(8'h51, q, st);
    in_valid = 1'b0;
    wait_idle(c);
    chk("q_len", c - q, FRAME + 1);
    chk_frame("q_frame", q + 1, 8'h51);

    // Backpressure: 0x7A held against a full FIFO
    push(8'h31, b, st);
    for (int i = 1; i < 5; i++) push(8'h31 + 8'(i), a, st);
    chk("bp_ready", in_ready, 0);
    push(8'h7A, z, st);
    in_data  = 8'h00;
    in_valid = 1'b0;
    chk("bp_acc", z, b + FRAME + 2);
    wait_idle(c);
    chk("bp_len", c - b, 6 * FRAME + 1);
    for (int i = 0; i < 5; i++)
      chk_frame($sformatf("bp_f%0d", i), b + 1 + FRAME * i, 8'h31 + 8'(i));
    chk_frame("bp_f7a", b + 1 + 5 * FRAME, 8'h7A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
